// File: rtl/pll_clkdiv_bank_pkg.sv
// Shared types and helpers for the clock-divider bank: FSM states, counter sizing,
// and the divide/phase clamps that map raw config fields to usable values.
package pll_clkdiv_pkg;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic int settle_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

    function automatic int sel_w(input int num_clocks);
        return (num_clocks > 1) ? $clog2(num_clocks) : 1;
    endfunction

    // A zero divide would stall the counter, so it behaves as divide-by-one.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

    function automatic logic [31:0] eff_phase(input logic [31:0] phase, input logic [31:0] d);
        return (phase >= d) ? (d - 32'd1) : phase;
    endfunction

endpackage

// File: rtl/pll_clkdiv_bank_if.sv
// Configuration write port of the clock-divider bank (valid/ready, one channel per transfer).
interface pll_clkdiv_bank_if #(
    parameter int NUM_CLOCKS = 3,
    parameter int DIV_W      = 8
);
    import pll_clkdiv_pkg::*;

    localparam int SEL_W = sel_w(NUM_CLOCKS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_sel, cfg_div, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_div, cfg_phase,
        output cfg_ready
    );

endinterface

// File: rtl/pll_clkdiv_bank_chan.sv
// One divider channel: free-running modulo-D counter with registered clock and enable outputs.
module clkdiv_chan #(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_eff,
    input  logic [DIV_W-1:0] phase_eff,
    input  logic             align,
    input  logic             run,
    output logic             outclk,
    output logic             outclk_en
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W:0]   half;

    // ceil(D/2): odd divides keep the clock high for the extra cycle
    assign half = ({1'b0, div_eff} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
        cnt_d = cnt_q;
        if (align) begin
            cnt_d = phase_eff;
        end else if (cnt_q >= div_eff - DIV_W'(1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Outputs are decoded from the next count so they line up with cnt in the same cycle.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            outclk    <= run && ({1'b0, cnt_d} < half);
            outclk_en <= run && (cnt_d == '0);
        end
    end

endmodule

// File: rtl/pll_clkdiv_bank.sv
// Reprogrammable clock-divider bank: shadow config registers, align/settle/lock sequencer,
// and one divider channel per output clock.
//   state  | meaning
//   ALIGN  | one cycle: all channel counters load their phase, outputs held low, config blocked
//   SETTLE | channels running, settle down-counter running, config accepted
//   LOCKED | channels running, locked high, config accepted
module pll_clkdiv_bank
    import pll_clkdiv_pkg::*;
#(
    parameter int                          NUM_CLOCKS    = 3,
    parameter int                          DIV_W         = 8,
    parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_DEFAULT   = {8'd1, 8'd5, 8'd2},
    parameter logic [NUM_CLOCKS*DIV_W-1:0] PHASE_DEFAULT = '0,
    parameter int                          LOCK_CYCLES   = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_clkdiv_bank_if.slave      cfg,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);

    localparam int SW = settle_w(LOCK_CYCLES);

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             locked_d;
    logic             ready;
    logic             accept;
    logic             sel_hit;
    logic             align;
    logic             run;
    logic [DIV_W-1:0] div_q   [NUM_CLOCKS];
    logic [DIV_W-1:0] phase_q [NUM_CLOCKS];

    assign ready         = (state_q != ALIGN);
    assign cfg.cfg_ready = ready;
    assign accept        = cfg.cfg_valid && ready;
    // Writes to a channel that does not exist complete the handshake but change nothing.
    assign sel_hit       = accept && (32'(cfg.cfg_sel) < NUM_CLOCKS);
    assign align         = (state_q == ALIGN);
    assign run           = (state_d != ALIGN);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        locked_d = locked;
        case (state_q)
            ALIGN: begin
                state_d  = SETTLE;
                settle_d = SW'(LOCK_CYCLES);
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            LOCKED: ;
            default: state_d = ALIGN;
        endcase
        if (sel_hit) begin
            state_d  = ALIGN;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ALIGN;
            settle_q <= '0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            locked   <= locked_d;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_q[i]   <= DIV_DEFAULT[i*DIV_W +: DIV_W];
                phase_q[i] <= PHASE_DEFAULT[i*DIV_W +: DIV_W];
            end
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (sel_hit && (32'(cfg.cfg_sel) == i)) begin
                    div_q[i]   <= cfg.cfg_div;
                    phase_q[i] <= cfg.cfg_phase;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        logic [DIV_W-1:0] d_eff;
        logic [DIV_W-1:0] p_eff;

        assign d_eff = DIV_W'(eff_div(32'(div_q[g])));
        assign p_eff = DIV_W'(eff_phase(32'(phase_q[g]), 32'(d_eff)));

        clkdiv_chan #(.DIV_W(DIV_W)) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .div_eff   (d_eff),
            .phase_eff (p_eff),
            .align     (align),
            .run       (run),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g])
        );
    end

endmodule

// File: tb/tb_pll_clkdiv_bank.sv
// Directed bench for pll_clkdiv_bank: default lock sequence, reconfiguration, clamping,
// out-of-range writes, back-to-back writes in SETTLE, and reset in the middle of SETTLE.
module tb_pll_clkdiv_bank;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic [2:0] outclk;
    logic [2:0] outclk_en;
    logic       locked;
    int         errors = 0;
    int         checks = 0;

    always #5 refclk = ~refclk;

    pll_clkdiv_bank_if #(.NUM_CLOCKS(3), .DIV_W(8)) cfg_if ();

    pll_clkdiv_bank #(
        .NUM_CLOCKS    (3),
        .DIV_W         (8),
        .DIV_DEFAULT   ({8'd1, 8'd5, 8'd2}),
        .PHASE_DEFAULT (24'd0),
        .LOCK_CYCLES   (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg       (cfg_if),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] div, input logic [7:0] ph);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_sel   = sel;
        cfg_if.cfg_div   = div;
        cfg_if.cfg_phase = ph;
    endtask

    // Expects rst high, sampled just after an edge; releases reset and walks to lock.
    task automatic reset_seq(input string tag);
        logic [2:0] exp_clk [6];
        logic [2:0] exp_en  [6];
        exp_clk = '{3'b111, 3'b110, 3'b111, 3'b100, 3'b101, 3'b110};
        exp_en  = '{3'b111, 3'b100, 3'b101, 3'b100, 3'b101, 3'b110};
        check({tag, "_rst_outclk"}, 32'(outclk), 32'd0);
        check({tag, "_rst_en"},     32'(outclk_en), 32'd0);
        check({tag, "_rst_locked"}, 32'(locked), 32'd0);
        check({tag, "_rst_ready"},  32'(cfg_if.cfg_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("%s_clk_e%0d", tag, i + 1), 32'(outclk), 32'(exp_clk[i]));
            check($sformatf("%s_en_e%0d", tag, i + 1),  32'(outclk_en), 32'(exp_en[i]));
        end
        check({tag, "_ready_settle"}, 32'(cfg_if.cfg_ready), 32'd1);
        step(11);
        check({tag, "_locked_e17"}, 32'(locked), 32'd0);
        step(1);
        check({tag, "_locked_e18"}, 32'(locked), 32'd1);
        check({tag, "_ready_e18"},  32'(cfg_if.cfg_ready), 32'd1);
    endtask

    initial begin
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(2);
        reset_seq("s1");

        // ch1 -> divide 4, phase 1 while locked
        drive(1'b1, 2'd1, 8'd4, 8'd1);
        step(1);
        check("s2_locked_drop", 32'(locked), 32'd0);
        check("s2_ready_align", 32'(cfg_if.cfg_ready), 32'd0);
        check("s2_clk_align",   32'(outclk), 32'd0);
        check("s2_en_align",    32'(outclk_en), 32'd0);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(1);
        check("s2_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        check("s2_clk_e20", 32'(outclk), 32'b111);
        check("s2_en_e20",  32'(outclk_en), 32'b101);
        step(1);
        check("s2_clk_e21", 32'(outclk), 32'b100);
        check("s2_en_e21",  32'(outclk_en), 32'b100);
        step(1);
        check("s2_clk_e22", 32'(outclk), 32'b101);
        check("s2_en_e22",  32'(outclk_en), 32'b101);
        step(1);
        check("s2_clk_e23", 32'(outclk), 32'b110);
        check("s2_en_e23",  32'(outclk_en), 32'b110);
        step(1);
        check("s2_clk_e24", 32'(outclk), 32'b111);
        check("s2_en_e24",  32'(outclk_en), 32'b101);
        step(12);
        check("s2_locked_e36", 32'(locked), 32'd0);
        step(1);
        check("s2_locked_e37", 32'(locked), 32'd1);

        // out-of-range channel select is a no-op
        drive(1'b1, 2'd3, 8'd7, 8'd2);
        step(1);
        check("s3_locked", 32'(locked), 32'd1);
        check("s3_ready",  32'(cfg_if.cfg_ready), 32'd1);
        check("s3_clk_e38", 32'(outclk), 32'b101);
        check("s3_en_e38",  32'(outclk_en), 32'b101);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(1);
        check("s3_clk_e39", 32'(outclk), 32'b110);
        check("s3_en_e39",  32'(outclk_en), 32'b110);

        // div=0 on ch0, then phase=9 with div=3 on ch2 during SETTLE
        drive(1'b1, 2'd0, 8'd0, 8'd5);
        step(1);
        check("s4_locked_w1", 32'(locked), 32'd0);
        check("s4_ready_w1",  32'(cfg_if.cfg_ready), 32'd0);
        drive(1'b1, 2'd2, 8'd3, 8'd9);
        step(1);
        check("s4_ready_e41", 32'(cfg_if.cfg_ready), 32'd1);
        check("s4_clk_e41",   32'(outclk), 32'b111);
        check("s4_en_e41",    32'(outclk_en), 32'b101);
        step(1);
        check("s4_ready_w2", 32'(cfg_if.cfg_ready), 32'd0);
        check("s4_clk_w2",   32'(outclk), 32'd0);
        check("s4_locked_w2", 32'(locked), 32'd0);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(1);
        check("s4_clk_e43", 32'(outclk), 32'b011);
        check("s4_en_e43",  32'(outclk_en), 32'b001);
        step(1);
        check("s4_clk_e44", 32'(outclk), 32'b101);
        check("s4_en_e44",  32'(outclk_en), 32'b101);
        step(1);
        check("s4_clk_e45", 32'(outclk), 32'b101);
        check("s4_en_e45",  32'(outclk_en), 32'b001);
        step(1);
        check("s4_clk_e46", 32'(outclk), 32'b011);
        check("s4_en_e46",  32'(outclk_en), 32'b011);

        // another write in SETTLE restarts the settle count
        drive(1'b1, 2'd1, 8'd4, 8'd1);
        step(1);
        check("s5_locked_w3", 32'(locked), 32'd0);
        check("s5_ready_w3",  32'(cfg_if.cfg_ready), 32'd0);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(13);
        check("s5_locked_e60", 32'(locked), 32'd0);
        step(4);
        check("s5_locked_e64", 32'(locked), 32'd0);
        step(1);
        check("s5_locked_e65", 32'(locked), 32'd1);

        // reconfigure ch0, then reset in the middle of SETTLE
        drive(1'b1, 2'd0, 8'd3, 8'd1);
        step(1);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step(3);
        check("s6_locked_settle", 32'(locked), 32'd0);
        check("s6_clk_e69",       32'(outclk), 32'b101);
        rst = 1'b1;
        #1;
        check("s6_async_clk",    32'(outclk), 32'd0);
        check("s6_async_en",     32'(outclk_en), 32'd0);
        check("s6_async_locked", 32'(locked), 32'd0);
        check("s6_async_ready",  32'(cfg_if.cfg_ready), 32'd0);
        step(1);
        reset_seq("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
